// File: rtl/mod1000_pkg.sv
// Shared types and constants for the mod-1000 counter and its BCD shadow.
// Also holds the binary-to-BCD split used when a counter load is accepted.
package mod1000_pkg;

  localparam int         MOD1000_WIDTH = 10;
  localparam int         MOD1000_MAX   = 999;
  localparam logic [3:0] BCD_MAX       = 4'd9;

  typedef logic [MOD1000_WIDTH-1:0] cnt_t;
  typedef logic [3:0]               bcd_t;

  typedef struct packed {
    bcd_t h;
    bcd_t t;
    bcd_t u;
  } bcd3_t;

  // Only reached for values below 1000, so every digit fits in four bits.
  function automatic bcd3_t to_bcd(input cnt_t v);
    bcd3_t r;
    r.h = bcd_t'(v / cnt_t'(100));
    r.t = bcd_t'((v / cnt_t'(10)) % cnt_t'(10));
    r.u = bcd_t'(v % cnt_t'(10));
    return r;
  endfunction

endpackage

// File: rtl/mod1000_counter_if.sv
// Request and status bundle of the mod-1000 counter.
// The master drives the requests; the slave (the counter) drives the registered status.
interface mod1000_counter_if #(
  parameter int WIDTH = 10
);

  logic             en;
  logic             up;
  logic             clr;
  logic             ld;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [3:0]       bcd_h;
  logic [3:0]       bcd_t;
  logic [3:0]       bcd_u;
  logic             wrap;
  logic             ld_err;

  modport master (
    output en, up, clr, ld, d,
    input  q, bcd_h, bcd_t, bcd_u, wrap, ld_err
  );

  modport slave (
    input  en, up, clr, ld, d,
    output q, bcd_h, bcd_t, bcd_u, wrap, ld_err
  );

endinterface

// File: rtl/mod1000_counter_bcd_digit.sv
// One registered mod-10 digit; load beats inc/dec, carry/borrow flag a roll-over this cycle.
// One-cycle latency; no backpressure, a request is taken on every edge.
module bcd_digit
  import mod1000_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic ld,
  input  bcd_t ld_val,
  output bcd_t digit,
  output logic carry,
  output logic borrow
);

  bcd_t digit_q;
  bcd_t digit_d;

  always_comb begin
    digit_d = digit_q;
    if (ld) begin
      digit_d = ld_val;
    end else if (inc) begin
      digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
    end else if (dec) begin
      digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  // Carry/borrow are combinational so the next digit steps on the same edge.
  assign carry  = !ld && inc && (digit_q == BCD_MAX);
  assign borrow = !ld && dec && (digit_q == 4'd0);
  assign digit  = digit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/mod1000_counter.sv
// Mod-1000 up/down counter with clear, range-checked load, BCD shadow and wrap pulse.
// All outputs registered, one-cycle latency; no backpressure (priority clr > ld > en).
module mod1000_counter
  import mod1000_pkg::*;
#(
  parameter int WIDTH   = MOD1000_WIDTH,
  parameter int MODULUS = MOD1000_MAX + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  mod1000_counter_if.slave   bus
);

  // One extra bit keeps the limit compares exact, with no reliance on truncation.
  localparam logic [WIDTH:0] MOD_X  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] LAST_X = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             ld_err_q, ld_err_d;

  logic [WIDTH:0]   q_x, d_x, q_up, q_dn;
  logic             ld_act, ld_ok, step, inc, dec, dig_ld;
  bcd3_t            ld_bcd;
  bcd_t             u_dig, t_dig, h_dig;
  logic             u_carry, u_borrow, t_carry, t_borrow, h_carry, h_borrow;

  assign q_x    = {1'b0, q_q};
  assign d_x    = {1'b0, bus.d};
  assign q_up   = q_x + (WIDTH+1)'(1);
  assign q_dn   = q_x - (WIDTH+1)'(1);

  assign ld_act = !bus.clr && bus.ld;
  assign ld_ok  = ld_act && (d_x < MOD_X);
  assign step   = !bus.clr && !bus.ld && bus.en;
  assign inc    = step && bus.up;
  assign dec    = step && !bus.up;

  always_comb begin
    q_d      = q_q;
    ld_err_d = ld_act && !ld_ok;
    if (bus.clr) begin
      q_d = '0;
    end else if (ld_ok) begin
      q_d = bus.d;
    end else if (inc) begin
      q_d = (q_x == LAST_X) ? '0 : q_up[WIDTH-1:0];
    end else if (dec) begin
      q_d = (q_x == '0) ? LAST_X[WIDTH-1:0] : q_dn[WIDTH-1:0];
    end
  end

  // A roll-over out of the hundreds digit is exactly the 999<->0 crossing.
  assign wrap_d = h_carry || h_borrow;

  assign dig_ld = bus.clr || ld_ok;
  assign ld_bcd = bus.clr ? '0 : to_bcd(cnt_t'(bus.d));

  bcd_digit u_units (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (inc),
    .dec    (dec),
    .ld     (dig_ld),
    .ld_val (ld_bcd.u),
    .digit  (u_dig),
    .carry  (u_carry),
    .borrow (u_borrow)
  );

  bcd_digit u_tens (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (u_carry),
    .dec    (u_borrow),
    .ld     (dig_ld),
    .ld_val (ld_bcd.t),
    .digit  (t_dig),
    .carry  (t_carry),
    .borrow (t_borrow)
  );

  bcd_digit u_hundreds (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (t_carry),
    .dec    (t_borrow),
    .ld     (dig_ld),
    .ld_val (ld_bcd.h),
    .digit  (h_dig),
    .carry  (h_carry),
    .borrow (h_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q      <= '0;
      wrap_q   <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      wrap_q   <= wrap_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign bus.q      = q_q;
  assign bus.bcd_h  = h_dig;
  assign bus.bcd_t  = t_dig;
  assign bus.bcd_u  = u_dig;
  assign bus.wrap   = wrap_q;
  assign bus.ld_err = ld_err_q;

endmodule

// File: doc/mod1000_counter.md
Name: mod1000_counter

Overview:
- Registered state stage of the mod-1000 counter path; holds the 10-bit binary count and a BCD shadow (hundreds/tens/units) kept in lockstep with it.
- Computes the next count (up/down wrap, clear, parallel load with range check) and presents it to the downstream 10-bit 2:1 select stage and the display logic.
- Emits a registered wrap pulse so counters can be cascaded.

Parameters:
- WIDTH, 10, binary count width; must satisfy 2**WIDTH >= MODULUS.
- MODULUS, 1000, count range 0..MODULUS-1; BCD shadow is defined for MODULUS = 1000 only.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- clr  input  1  synchronous clear to 0.
- ld  input  1  synchronous parallel load of d.
- d  input  WIDTH  load value.
- q  output  WIDTH  registered binary count.
- bcd_h  output  4  registered hundreds digit of q.
- bcd_t  output  4  registered tens digit of q.
- bcd_u  output  4  registered units digit of q.
- wrap  output  1  registered one-cycle pulse: count crossed 999->0 (up) or 0->999 (down).
- ld_err  output  1  registered one-cycle pulse: load rejected, d >= MODULUS.

Behaviour:
- Clocking and reset: single clock, asynchronous active-low reset rst_n.
- While rst_n=0, regardless of clk: q=0, bcd_h=bcd_t=bcd_u=0, wrap=0, ld_err=0. Release is synchronous to the next rising edge; the first count happens on the first edge with rst_n=1 and en=1.
- Priority per edge: clr > ld > en > hold. Only the highest-priority active request takes effect.
- clr=1: q<=0, all BCD digits <=0, wrap<=0, ld_err<=0.
- ld=1 (clr=0), d < MODULUS: q<=d, BCD digits <= decimal digits of d, wrap<=0, ld_err<=0.
- ld=1 (clr=0), d >= MODULUS: q and BCD hold, ld_err<=1 for exactly one cycle, wrap<=0. Any en in that cycle is ignored.
- en=1, up=1: q<=q+1, or 0 if q=999.
  - BCD: units +1; on units=9 the units digit goes to 0 and carries into tens; tens=9 carries into hundreds.
  - wrap<=1 only on the 999->0 step.
- en=1, up=0: q<=q-1, or 999 if q=0.
  - BCD borrows mirror the increment carries.
  - wrap<=1 only on the 0->999 step.
- Idle (en=0, no clr/ld): all registers hold; wrap and ld_err return to 0.
- Latency: q, BCD digits, wrap and ld_err all reflect a request on the edge that samples it, i.e. 1 cycle. There is no combinational path from inputs to outputs.
- Invariants:
  - q is never >= MODULUS.
  - Each BCD digit is never > 9.
  - bcd_h*100 + bcd_t*10 + bcd_u == q at every cycle after reset.
- Width rules: next-value arithmetic uses WIDTH+1 bits internally so the compare against 999 is exact; there is no truncation-based wrap.
- Reset mid-count: asynchronous assertion zeroes all state immediately; any in-flight pulse (wrap/ld_err) is cleared.
- Simultaneous events:
  - clr with ld and/or en: clr wins.
  - ld with en: ld wins and no step occurs, even if the load is rejected.

Decomposition:
- Package mod1000_pkg holds:
  - constants MOD1000_WIDTH=10, MOD1000_MAX=999, BCD_MAX=4'd9;
  - typedef cnt_t (logic [9:0]);
  - typedef bcd_t (logic [3:0]).
- Sub-module bcd_digit: one mod-10 digit with inputs inc, dec, ld, ld_val and outputs digit, carry, borrow; three instances are chained units->tens->hundreds.
- Binary q next-state logic and the range check stay in the top module.

Test Plan:
- Reset then en=1, up=1 for 1000 cycles -> q runs 0..999 then 0; wrap=1 only on the cycle q becomes 0; BCD matches q on every cycle.
- ld=1, d=998, then en=1, up=1 for 3 cycles -> q=998, 999, 0, 1; BCD 9/9/9 then 0/0/0; one wrap pulse.
- clr=0, ld=1, d=1000 (q=123) -> q stays 123, BCD stays 1/2/3, ld_err=1 for one cycle, then 0.
- From q=0: en=1, up=0 for 2 cycles -> q=999 (wrap=1), then 998 (wrap=0); BCD 9/9/9 then 9/9/8.
- Same-cycle requests: clr=1, ld=1, d=500, en=1 at q=42 -> q=0; then ld=1, d=500, en=1, up=1 -> q=500, not 501.
- Assert rst_n=0 asynchronously mid-cycle at q=777 -> q, BCD, wrap and ld_err go to 0 before the next edge; counting resumes from 0 after release.
